tlv5618_rx_decoder: RTL and testbench

Serial-frame receiver for the TLV5618 three-wire DAC interface (cs, dac_clk, series data). It deserializes 16-bit frames, decodes the 4 control bits, and maintains a register model of the TLV5618: DAC A, DAC B, the double buffer, and the speed and power bits. It sits on the far side of our DAC serial writer. Uses: loopback self-check on the board, and a synthesizable DAC stand-in when the chip is not fitted.

---
 rtl/tlv5618_rx_decoder_if.sv | 38 +++
 rtl/tlv5618_rx_decoder.sv | 174 +++++++++++++++++
 tb/tb_tlv5618_rx_decoder.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/tlv5618_rx_decoder_if.sv
// -----------------------------------------------------------------------------
// tlv5618_rx_decoder_if
// Bundles the TLV5618 three-wire serial bus together with the decoded register
// view produced by the receiver.
//   cs, dac_clk, series_dac_in : serial bus (driven by the DAC writer)
//   frame_data, frame_valid, frame_err : last frame and its status pulses
//   dac_a, dac_b, dac_buf, spd, pwr    : TLV5618 register model
//   busy                               : frame being shifted
// Modports:
//   master : the serial writer side (drives the bus, observes the decode)
//   slave  : the receiver/decoder side
// -----------------------------------------------------------------------------
interface tlv5618_rx_decoder_if;
    logic        cs;
    logic        dac_clk;
    logic        series_dac_in;
    logic [15:0] frame_data;
    logic        frame_valid;
    logic        frame_err;
    logic [11:0] dac_a;
    logic [11:0] dac_b;
    logic [11:0] dac_buf;
    logic        spd;
    logic        pwr;
    logic        busy;

    modport master (
        output cs, dac_clk, series_dac_in,
        input  frame_data, frame_valid, frame_err,
        input  dac_a, dac_b, dac_buf, spd, pwr, busy
    );

    modport slave (
        input  cs, dac_clk, series_dac_in,
        output frame_data, frame_valid, frame_err,
        output dac_a, dac_b, dac_buf, spd, pwr, busy
    );
endinterface

// File: rtl/tlv5618_rx_decoder.sv
// -----------------------------------------------------------------------------
// tlv5618_rx_decoder
// Receives 16-bit TLV5618 serial frames (cs / dac_clk / series_dac_in),
// decodes the control bits and keeps a register model of the DAC:
// DAC A, DAC B, the double-buffer latch, speed and power-down bits.
// Ports:
//   sys_clk   : system clock, all logic on the rising edge
//   sys_rst_n : asynchronous active-low reset
//   bus       : tlv5618_rx_decoder_if.slave (serial inputs, decoded outputs)
// Parameter:
//   SYNC_STAGES : synchronizer depth on the three serial inputs (>= 2)
// -----------------------------------------------------------------------------
module tlv5618_rx_decoder #(
    parameter int SYNC_STAGES = 2
) (
    input  logic                   sys_clk,
    input  logic                   sys_rst_n,
    tlv5618_rx_decoder_if.slave    bus
);

    typedef enum logic [1:0] {
        ARM   = 2'd0,
        IDLE  = 2'd1,
        SHIFT = 2'd2
    } state_t;

    localparam int MSB = SYNC_STAGES - 1;

    // Synchronizers, all the same depth so the three paths stay aligned.
    logic [SYNC_STAGES-1:0] cs_sync_q;
    logic [SYNC_STAGES-1:0] clk_sync_q;
    logic [SYNC_STAGES-1:0] din_sync_q;
    // Marks when the synchronizer contents come from the pins rather than
    // from the reset levels; ARM must not trust cs before that.
    logic [SYNC_STAGES-1:0] fill_q;
    logic                   cs_prev_q;
    logic                   clk_prev_q;

    logic cs_s, clk_s, din_s;
    logic cs_fall, cs_rise, clk_fall;

    state_t      state_q;
    logic [15:0] shift_q;
    logic [15:0] shift_d;
    logic [4:0]  cnt_q;
    logic [4:0]  cnt_d;
    logic [15:0] frame_data_q;
    logic        frame_valid_q;
    logic        frame_err_q;
    logic [11:0] dac_a_q;
    logic [11:0] dac_b_q;
    logic [11:0] dac_buf_q;
    logic        spd_q;
    logic        pwr_q;
    logic        busy_q;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cs_sync_q  <= '1;
            clk_sync_q <= '0;
            din_sync_q <= '0;
            fill_q     <= '0;
            cs_prev_q  <= 1'b1;
            clk_prev_q <= 1'b0;
        end else begin
            cs_sync_q  <= {cs_sync_q[SYNC_STAGES-2:0],  bus.cs};
            clk_sync_q <= {clk_sync_q[SYNC_STAGES-2:0], bus.dac_clk};
            din_sync_q <= {din_sync_q[SYNC_STAGES-2:0], bus.series_dac_in};
            fill_q     <= {fill_q[SYNC_STAGES-2:0], 1'b1};
            cs_prev_q  <= cs_sync_q[MSB];
            clk_prev_q <= clk_sync_q[MSB];
        end
    end

    assign cs_s     = cs_sync_q[MSB];
    assign clk_s    = clk_sync_q[MSB];
    assign din_s    = din_sync_q[MSB];
    assign cs_fall  = cs_prev_q & ~cs_s;
    assign cs_rise  = ~cs_prev_q & cs_s;
    assign clk_fall = clk_prev_q & ~clk_s;

    // Shift-in and saturating bit count; saturating at 17 keeps overlong
    // frames distinguishable from exact 16-bit ones.
    always_comb begin
        shift_d = {shift_q[14:0], din_s};
        cnt_d   = (cnt_q >= 5'd17) ? 5'd17 : cnt_q + 5'd1;
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q       <= ARM;
            shift_q       <= '0;
            cnt_q         <= '0;
            frame_data_q  <= '0;
            frame_valid_q <= 1'b0;
            frame_err_q   <= 1'b0;
            dac_a_q       <= '0;
            dac_b_q       <= '0;
            dac_buf_q     <= '0;
            spd_q         <= 1'b0;
            pwr_q         <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            frame_valid_q <= 1'b0;
            frame_err_q   <= 1'b0;
            case (state_q)
                ARM: begin
                    if (fill_q[MSB] && cs_s) begin
                        state_q <= IDLE;
                    end
                end
                IDLE: begin
                    if (cs_fall) begin
                        shift_q <= '0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    // cs deassertion takes priority over a coincident clock fall.
                    if (cs_rise) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                        if (cnt_q == 5'd16) begin
                            frame_data_q  <= shift_q;
                            frame_valid_q <= 1'b1;
                            // {R1,R0} selects the register update.
                            case ({shift_q[15], shift_q[12]})
                                2'b00: begin
                                    dac_b_q   <= shift_q[11:0];
                                    dac_buf_q <= shift_q[11:0];
                                end
                                2'b01: begin
                                    dac_buf_q <= shift_q[11:0];
                                end
                                2'b10: begin
                                    dac_a_q <= shift_q[11:0];
                                    dac_b_q <= dac_buf_q;
                                end
                                default: begin
                                end
                            endcase
                            if (!(shift_q[15] && shift_q[12])) begin
                                spd_q <= shift_q[14];
                                pwr_q <= shift_q[13];
                            end
                        end else begin
                            frame_err_q <= 1'b1;
                        end
                    end else if (clk_fall) begin
                        shift_q <= shift_d;
                        cnt_q   <= cnt_d;
                    end
                end
                default: begin
                    state_q <= ARM;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.frame_data  = frame_data_q;
    assign bus.frame_valid = frame_valid_q;
    assign bus.frame_err   = frame_err_q;
    assign bus.dac_a       = dac_a_q;
    assign bus.dac_b       = dac_b_q;
    assign bus.dac_buf     = dac_buf_q;
    assign bus.spd         = spd_q;
    assign bus.pwr         = pwr_q;
    assign bus.busy        = busy_q;

endmodule

// File: tb/tb_tlv5618_rx_decoder.sv
// -----------------------------------------------------------------------------
// tb_tlv5618_rx_decoder
// Drives serial frames into tlv5618_rx_decoder and checks the decoded
// register view against a frame-level reference model through a scoreboard.
// -----------------------------------------------------------------------------
module tb_tlv5618_rx_decoder;

    logic sys_clk = 1'b0;
    logic sys_rst_n = 1'b0;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    int   pulses = 0;

    tlv5618_rx_decoder_if bus();

    tlv5618_rx_decoder #(.SYNC_STAGES(2)) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .bus       (bus)
    );

    always #5 sys_clk = ~sys_clk;
    always @(posedge sys_clk) cyc <= cyc + 1;

    typedef struct {
        bit          ok;
        logic [15:0] fd;
        logic [11:0] a;
        logic [11:0] b;
        logic [11:0] dbuf;
        logic        spd;
        logic        pwr;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];

    // Reference register model of the DAC.
    logic [15:0] m_fd;
    logic [11:0] m_a, m_b, m_dbuf;
    logic        m_spd, m_pwr;

    task automatic model_reset();
        m_fd = '0; m_a = '0; m_b = '0; m_dbuf = '0; m_spd = 1'b0; m_pwr = 1'b0;
    endtask

    // Applies one closed frame of n bits (last 16 bits in w) to the model and
    // returns the expected observation.
    task automatic model_frame(input logic [15:0] w, input int n, output exp_t e);
        logic [11:0] data;
        logic [11:0] old_buf;
        data    = w[11:0];
        old_buf = m_dbuf;
        e.ok    = (n == 16);
        if (n == 16) begin
            m_fd = w;
            if (w[15] == 1'b0 && w[12] == 1'b0) begin
                m_b = data; m_dbuf = data;
            end else if (w[15] == 1'b0) begin
                m_dbuf = data;
            end else if (w[12] == 1'b0) begin
                m_a = data; m_b = old_buf;
            end
            if (!(w[15] && w[12])) begin
                m_spd = w[14]; m_pwr = w[13];
            end
        end
        e.fd = m_fd; e.a = m_a; e.b = m_b; e.dbuf = m_dbuf;
        e.spd = m_spd; e.pwr = m_pwr; e.cyc = 0;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: pops the scoreboard on every status pulse.
    always @(negedge sys_clk) begin
        if (sys_rst_n && (bus.frame_valid || bus.frame_err)) begin
            exp_t e;
            pulses++;
            if (exp_q.size() == 0) begin
                chk("unexpected_pulse", {30'd0, bus.frame_valid, bus.frame_err}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("frame_valid", {31'd0, bus.frame_valid}, {31'd0, e.ok});
                chk("frame_err",   {31'd0, bus.frame_err},   {31'd0, !e.ok});
                chk("frame_data",  {16'd0, bus.frame_data},  {16'd0, e.fd});
                chk("dac_a",       {20'd0, bus.dac_a},       {20'd0, e.a});
                chk("dac_b",       {20'd0, bus.dac_b},       {20'd0, e.b});
                chk("dac_buf",     {20'd0, bus.dac_buf},     {20'd0, e.dbuf});
                chk("spd",         {31'd0, bus.spd},         {31'd0, e.spd});
                chk("pwr",         {31'd0, bus.pwr},         {31'd0, e.pwr});
                chk("busy_at_pulse", {31'd0, bus.busy}, 32'd0);
                chk("pulse_latency", cyc, e.cyc + 3);
            end
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    // Shifts the low n bits of v, MSB first; each clock level lasts 2 cycles.
    task automatic shift_bits(input logic [31:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            bus.series_dac_in = v[i];
            bus.dac_clk = 1'b1;
            wait_cyc(2);
            bus.dac_clk = 1'b0;
            wait_cyc(2);
        end
    endtask

    task automatic send_frame(input logic [31:0] v, input int n, input int gap);
        exp_t e;
        bus.cs = 1'b0;
        bus.dac_clk = 1'b0;
        wait_cyc(2);
        shift_bits(v, n);
        model_frame(v[15:0], n, e);
        e.cyc = cyc;
        exp_q.push_back(e);
        bus.cs = 1'b1;
        bus.series_dac_in = 1'b0;
        wait_cyc(gap);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_frame_data"},  {16'd0, bus.frame_data}, 32'd0);
        chk({tag, "_frame_valid"}, {31'd0, bus.frame_valid}, 32'd0);
        chk({tag, "_frame_err"},   {31'd0, bus.frame_err}, 32'd0);
        chk({tag, "_dac_a"},       {20'd0, bus.dac_a}, 32'd0);
        chk({tag, "_dac_b"},       {20'd0, bus.dac_b}, 32'd0);
        chk({tag, "_dac_buf"},     {20'd0, bus.dac_buf}, 32'd0);
        chk({tag, "_spd"},         {31'd0, bus.spd}, 32'd0);
        chk({tag, "_pwr"},         {31'd0, bus.pwr}, 32'd0);
        chk({tag, "_busy"},        {31'd0, bus.busy}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, queue=%0d", exp_q.size());
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        int n;
        logic [31:0] v;
        model_reset();
        bus.cs = 1'b0;
        bus.dac_clk = 1'b0;
        bus.series_dac_in = 1'b0;

        // Reset with a frame already in progress; it must be ignored.
        wait_cyc(1);
        #1;
        check_reset_outputs("reset");
        p0 = pulses;
        shift_bits(32'h00A5, 8);
        sys_rst_n = 1'b1;
        shift_bits(32'h005A, 8);
        bus.cs = 1'b1;
        wait_cyc(8);
        chk("no_pulse_inflight_frame", pulses - p0, 0);

        // Directed frames.
        send_frame(32'h1123, 16, 6);
        chk("dac_buf_1123", {20'd0, bus.dac_buf}, 32'h123);
        chk("dac_a_1123",   {20'd0, bus.dac_a}, 32'h0);
        send_frame(32'hC5A3, 16, 6);
        chk("dac_a_C5A3", {20'd0, bus.dac_a}, 32'h5A3);
        chk("dac_b_C5A3", {20'd0, bus.dac_b}, 32'h123);
        chk("spd_C5A3",   {31'd0, bus.spd}, 32'd1);
        send_frame(32'h0FFF, 16, 2);
        send_frame(32'h9ABC, 16, 6);
        chk("dac_b_after_reserved", {20'd0, bus.dac_b}, 32'hFFF);
        chk("frame_data_9ABC", {16'd0, bus.frame_data}, 32'h9ABC);

        // Malformed frames: 15 bits, 18 bits, zero clocks.
        p0 = pulses;
        send_frame(32'h1234, 15, 2);
        send_frame(32'h3FFFF, 18, 2);
        send_frame(32'h0, 0, 6);
        chk("err_pulse_count", pulses - p0, 3);
        chk("frame_data_after_err", {16'd0, bus.frame_data}, 32'h9ABC);

        // Reset in the middle of frame 0x2555.
        bus.cs = 1'b0;
        wait_cyc(2);
        shift_bits(32'h25, 8);
        p0 = pulses;
        sys_rst_n = 1'b0;
        model_reset();
        #1;
        check_reset_outputs("midreset");
        wait_cyc(3);
        sys_rst_n = 1'b1;
        wait_cyc(3);
        bus.cs = 1'b1;
        wait_cyc(6);
        chk("no_pulse_after_midreset", pulses - p0, 0);
        send_frame(32'h2555, 16, 6);
        chk("dac_buf_2555", {20'd0, bus.dac_buf}, 32'h555);
        chk("pwr_2555",     {31'd0, bus.pwr}, 32'd1);

        // Randomized frames, mostly well-formed.
        for (int k = 0; k < 40; k++) begin
            v = $urandom;
            n = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 20) : 16;
            send_frame(v, n, $urandom_range(2, 5));
        end

        wait_cyc(10);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
